// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry first-word-fall-through queue of {pc+4, instruction}
// pairs sitting between fetch and decode. An empty queue presents a NOP bubble
// (all-zero instruction and pc+4). A redirect flush empties the queue in one cycle.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both 1
// on that side (push = push_valid_i & push_ready_o, pop = pop_valid_o & pop_ready_i).
// push_ready_o is a function of registered occupancy only, so a full queue refuses
// a push even in a cycle where decode pops. pop_valid_o and the head data are
// combinational from registered state, and decode may sample them in the same cycle.
module fetch_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_valid_i,
  input  logic [INST_W-1:0] push_inst_i,
  input  logic [PC_W-1:0]   push_pc4_i,
  output logic              push_ready_o,
  output logic              pop_valid_o,
  output logic [INST_W-1:0] pop_inst_o,
  output logic [PC_W-1:0]   pop_pc4_o,
  input  logic              pop_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [PC_W-1:0]   pc4_mem_q  [DEPTH];
  logic [PC_W-1:0]   pc4_mem_d  [DEPTH];

  logic push;
  logic pop;

  // Handshake and head presentation; bubble is forced to zero when empty.
  always_comb begin
    push_ready_o = (count_q != CNT_W'(DEPTH));
    pop_valid_o  = (count_q != '0);
    push         = push_valid_i & push_ready_o;
    pop          = pop_ready_i & pop_valid_o;
    pop_inst_o   = pop_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    pop_pc4_o    = pop_valid_o ? pc4_mem_q[rd_ptr_q]  : '0;
    count_o      = count_q;
    ovf_err_o    = ovf_q;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag; flush wins.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_valid_i & ~push_ready_o & ~flush_i);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage write; a push dropped by flush leaves the array untouched.
  always_comb begin
    inst_mem_d = inst_mem_q;
    pc4_mem_d  = pc4_mem_q;
    if (push && !flush_i) begin
      inst_mem_d[wr_ptr_q] = push_inst_i;
      pc4_mem_d[wr_ptr_q]  = push_pc4_i;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage register; contents are only meaningful where count says so.
  always_ff @(posedge clk_i) begin
    inst_mem_q <= inst_mem_d;
    pc4_mem_q  <= pc4_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a scoreboard. The driver
// pushes expected {pc4, inst} pairs into exp_q when the bench's own occupancy
// model says a push is accepted; a negedge monitor compares the DUT head, count,
// ready/valid, bubble and overflow flag against that queue.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_i;
  logic             rst_i;
  logic             flush_i;
  logic             push_valid_i;
  logic [31:0]      push_inst_i;
  logic [31:0]      push_pc4_i;
  logic             push_ready_o;
  logic             pop_valid_o;
  logic [31:0]      pop_inst_o;
  logic [31:0]      pop_pc4_o;
  logic             pop_ready_i;
  logic [CNT_W-1:0] count_o;
  logic             ovf_err_o;

  logic [63:0] exp_q[$];
  logic        m_ovf;
  int          tests_run;
  int          tests_failed;

  fetch_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_valid_i(push_valid_i),
    .push_inst_i (push_inst_i),
    .push_pc4_i  (push_pc4_i),
    .push_ready_o(push_ready_o),
    .pop_valid_o (pop_valid_o),
    .pop_inst_o  (pop_inst_o),
    .pop_pc4_o   (pop_pc4_o),
    .pop_ready_i (pop_ready_i),
    .count_o     (count_o),
    .ovf_err_o   (ovf_err_o)
  );

  // Clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: applies one cycle of inputs just after a rising edge and updates the
  // model with the outcome of the edge that consumes them.
  task automatic step(input logic fl, input logic pv, input logic [31:0] inst,
                      input logic [31:0] pc4, input logic pr);
    logic acc;
    logic refuse;
    flush_i      = fl;
    push_valid_i = pv;
    push_inst_i  = inst;
    push_pc4_i   = pc4;
    pop_ready_i  = pr;
    acc    = pv && !fl && (exp_q.size() < DEPTH);
    refuse = pv && !fl && (exp_q.size() >= DEPTH);
    @(posedge clk_i);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back({pc4, inst});
    if (refuse) m_ovf = 1'b1;
    #1;
  endtask

  task automatic idle(input int n, input logic pr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, pr);
  endtask

  // Monitor / scoreboard: sampled on the falling edge, away from the update edge.
  always @(negedge clk_i) begin : monitor
    int n;
    if (!rst_i) begin
      n = exp_q.size();
      check("count", 64'(count_o), 64'(n));
      check("push_ready", 64'(push_ready_o), 64'(n < DEPTH));
      check("pop_valid", 64'(pop_valid_o), 64'(n != 0));
      check("ovf_err", 64'(ovf_err_o), 64'(m_ovf));
      if (!pop_valid_o) begin
        check("bubble_inst", 64'(pop_inst_o), 64'h0);
        check("bubble_pc4", 64'(pop_pc4_o), 64'h0);
      end else if (n != 0) begin
        check("head", {pop_pc4_o, pop_inst_o}, exp_q[0]);
        if (pop_ready_i && !flush_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_ovf        = 1'b0;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    push_valid_i = 1'b0;
    push_inst_i  = '0;
    push_pc4_i   = '0;
    pop_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", 64'(count_o), 64'h0);
    check("rst_push_ready", 64'(push_ready_o), 64'h1);
    check("rst_pop_valid", 64'(pop_valid_o), 64'h0);
    rst_i = 1'b0;

    // Empty pop is ignored; one-cycle latency with no bypass.
    idle(1, 1'b1);
    step(1'b0, 1'b1, 32'hAAAAAAAA, 32'h00000100, 1'b1);
    idle(3, 1'b1);

    // Fill to DEPTH, then a refused fifth push raises the sticky overflow flag.
    step(1'b0, 1'b1, 32'h11111111, 32'h00000004, 1'b0);
    step(1'b0, 1'b1, 32'h22222222, 32'h00000008, 1'b0);
    step(1'b0, 1'b1, 32'h33333333, 32'h0000000C, 1'b0);
    step(1'b0, 1'b1, 32'h44444444, 32'h00000010, 1'b0);
    step(1'b0, 1'b1, 32'h99999999, 32'h00000018, 1'b0);

    // Drain through the pointer wrap while fetch keeps offering.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h55555555, 32'h00000014, 1'b1);
    idle(5, 1'b1);

    // Flush with a simultaneous push: the pushed word must never emerge.
    step(1'b0, 1'b1, 32'h0000A001, 32'h00000020, 1'b0);
    step(1'b0, 1'b1, 32'h0000A002, 32'h00000024, 1'b0);
    step(1'b0, 1'b1, 32'h0000A003, 32'h00000028, 1'b0);
    step(1'b1, 1'b1, 32'hDEADBEEF, 32'h0000BEEF, 1'b0);
    idle(2, 1'b1);

    // Stall holds the head, release pops in order, then a bubble.
    step(1'b0, 1'b1, 32'h0000B001, 32'h00000030, 1'b0);
    step(1'b0, 1'b1, 32'h0000B002, 32'h00000034, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Asynchronous reset mid-cycle with entries queued.
    step(1'b0, 1'b1, 32'h0000C001, 32'h00000040, 1'b0);
    step(1'b0, 1'b1, 32'h0000C002, 32'h00000044, 1'b0);
    step(1'b0, 1'b1, 32'h0000C003, 32'h00000048, 1'b0);
    push_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_pop_valid", 64'(pop_valid_o), 64'h0);
    check("async_rst_inst", 64'(pop_inst_o), 64'h0);
    check("async_rst_pc4", 64'(pop_pc4_o), 64'h0);
    check("async_rst_count", 64'(count_o), 64'h0);
    check("async_rst_push_ready", 64'(push_ready_o), 64'h1);
    check("async_rst_ovf", 64'(ovf_err_o), 64'h0);
    exp_q.delete();
    m_ovf = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Normal operation resumes after reset.
    step(1'b0, 1'b1, 32'h0000D001, 32'h00000050, 1'b1);
    idle(3, 1'b1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
